fxp_accum_quant: RTL and testbench
==================================

// Module: fxp_accum_quant
// PURPOSE
// Pipelined signed fixed-point accumulator: sums N_ACC consecutive valid samples at full resolution.
// Each result is re-quantised to the output format. Rounding and overflow mode are selected at run time.
// Sits after the sample-rate datapath (decimator / averager front end).
// Generalises the combinational adder/quantiser: depth, formats and mode are all parametrised.
// PARAMETERS
// NB_IN    16  input total bits, signed
// NBF_IN   14  input fractional bits
// N_ACC    4   samples per window, >=2
// NB_OUT   11  output total bits
// NBF_OUT  10  output fractional bits; NBF_OUT<=NBF_IN, NB_OUT-NBF_OUT<=NB_ACC-NBF_IN
// NB_ACC   NB_IN+$clog2(N_ACC)  derived full-res width (localparam), frac = NBF_IN
// PORTS
// i_clock    in   1       clock, rising edge
// i_rst_n    in   1       synchronous reset, active low
// i_clear    in   1       abort current partial window
// i_valid    in   1       i_data valid this cycle
// i_data     in   NB_IN   signed sample S(NB_IN,NBF_IN)
// i_mode     in   2       [0]: 0=truncate 1=round; [1]: 0=wrap 1=saturate
// o_valid    out  1       one-cycle result strobe
// o_acc_fr   out  NB_ACC  full-resolution window sum
// o_data     out  NB_OUT  quantised sum S(NB_OUT,NBF_OUT)
// o_ovf      out  1       sum exceeded output range (in either mode), qualified by o_valid
// BEHAVIOUR
// - Reset (i_rst_n=0 at edge): cnt, acc, pipeline flags, o_valid, o_acc_fr, o_data, o_ovf all <=0.
//   Reset mid-window discards partial sum and in-flight result.
// - Stage 1, each i_valid=1:
//   - x = sign-extend(i_data) to NB_ACC.
//   - If cnt==0: acc<=x; else acc<=acc+x.
//   - cnt<=cnt+1, or 0 when cnt==N_ACC-1.
//   - On the last sample, done_q<=1 and mode_q<=i_mode (mode sampled at window end).
//   - i_valid=0 holds cnt/acc. Gaps between samples are allowed.
// - Stage 2, when done_q=1: register o_acc_fr<=acc, o_data<=quant(acc,mode_q), o_ovf, o_valid<=1.
//   Otherwise o_valid<=0 and data outputs hold their last value.
// - Latency: last sample at edge t -> o_valid high for exactly cycle t+2.
//   Back-to-back windows run with no dead cycle (cnt==0 loads fresh).
// - i_clear=1: cnt<=0, partial acc dropped.
//   If i_valid=1 in the same cycle, that sample starts the new window (acc<=x, cnt<=1).
//   A result already in stage 2 is still emitted. Reset has priority over i_clear.
// - quant():
//   - Round adds 2^-(NBF_OUT+1) (half output LSB, round-half-up) on NB_ACC+1 bits before dropping NBF_IN-NBF_OUT LSBs.
//     Truncate drops them (floor).
//   - Overflow when the dropped MSBs plus output sign bit are not all equal.
//   - Wrap: keep the low NB_OUT bits.
//   - Saturate: 0 followed by all 1s if the sign is positive; 1 followed by all 0s if negative.
//   - o_ovf=1 on overflow in both modes.
// STRUCTURE
// - Shared package: mode bit positions (MODE_RND_BIT=0, MODE_SAT_BIT=1) and encodings.
// - Sub-module fxp_quantizer: combinational, parametrised by in/out formats.
//   Rounding, overflow detect, wrap/sat select. Instantiated once in stage 2.
// - Top holds counter, accumulator and the two register stages.
// TESTING (defaults; N_ACC=4; S(11,10) range [-1,1-2^-10])
// 1. 4x 16'h1000 (+0.25), mode=00 -> o_data=11'h400, o_ovf=1, o_acc_fr=1.0.
//    Same stimulus, mode=10 -> o_data=11'h3FF, o_ovf=1.
// 2. 4x 16'h0002 (sum 2^-11): mode=00 -> 11'h000; mode=01 -> 11'h001; o_ovf=0 for both.
// 3. 4x 16'hC000 (-1.0, sum -4.0): mode=10 -> 11'h400, o_ovf=1; mode=00 -> 11'h000, o_ovf=1.
// 4. 8 consecutive valids, then 8 with random gaps -> exactly one o_valid pulse per window.
//    Each pulse lands 2 cycles after the 4th sample; sums match the reference model.
// 5. 2 samples, then i_rst_n=0 for 1 cycle -> all outputs 0.
//    The next 4 samples give o_valid once, with the sum of only those 4.
// 6. 3 samples, then i_clear=1 together with i_valid (value v) -> next o_valid follows 3 more samples.
//    o_acc_fr = v + those 3 samples.

Source files
------------

// File: rtl/fxp_accum_quant_pkg.sv
// Shared types/constants for the fixed-point accumulator/quantiser.
// Mode word bit positions and encodings.
package fxp_accum_quant_pkg;

  localparam int MODE_RND_BIT = 0;
  localparam int MODE_SAT_BIT = 1;

  typedef logic [1:0] mode_t;

  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_ROUND = 1'b1
  } rnd_e;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_e;

  localparam mode_t MODE_TRUNC_WRAP = 2'b00;
  localparam mode_t MODE_ROUND_WRAP = 2'b01;
  localparam mode_t MODE_TRUNC_SAT  = 2'b10;
  localparam mode_t MODE_ROUND_SAT  = 2'b11;

endpackage

// File: rtl/fxp_accum_quant_if.sv
// Sample/result bundle of the accumulator/quantiser.
// master: sample source + result sink; slave: the datapath.
interface fxp_accum_quant_if #(
  parameter int NB_IN  = 16,
  parameter int NB_OUT = 11,
  parameter int NB_ACC = 18
);
  import fxp_accum_quant_pkg::*;

  logic              i_clear;
  logic              i_valid;
  logic [NB_IN-1:0]  i_data;
  mode_t             i_mode;
  logic              o_valid;
  logic [NB_ACC-1:0] o_acc_fr;
  logic [NB_OUT-1:0] o_data;
  logic              o_ovf;

  modport master (
    output i_clear, i_valid, i_data, i_mode,
    input  o_valid, o_acc_fr, o_data, o_ovf
  );

  modport slave (
    input  i_clear, i_valid, i_data, i_mode,
    output o_valid, o_acc_fr, o_data, o_ovf
  );

endinterface

// File: rtl/fxp_accum_quant_quantizer.sv
// Combinational re-quantiser S(NB_IN,NBF_IN) -> S(NB_OUT,NBF_OUT).
// Ports: din, mode in; dout, ovf out. Trunc/round, wrap/saturate.
module fxp_quantizer
  import fxp_accum_quant_pkg::*;
#(
  parameter int NB_IN   = 18,
  parameter int NBF_IN  = 14,
  parameter int NB_OUT  = 11,
  parameter int NBF_OUT = 10
) (
  input  logic [NB_IN-1:0]  din,
  input  mode_t             mode,
  output logic [NB_OUT-1:0] dout,
  output logic              ovf
);

  localparam int D      = NBF_IN - NBF_OUT;
  localparam int NB_EXT = NB_IN + 1;
  localparam int NB_SH  = NB_EXT - D;

  logic signed [NB_EXT-1:0] ext;
  logic signed [NB_EXT-1:0] rnd;
  logic        [NB_EXT-1:0] half;
  logic        [NB_SH-1:0]  sh;
  logic [NB_SH-NB_OUT:0]    top;
  logic [NB_OUT-1:0]        sat;

  // Half output LSB; nothing to add when no bits are dropped.
  if (D > 0) begin : g_half
    assign half = NB_EXT'(1) << (D - 1);
  end else begin : g_nohalf
    assign half = '0;
  end

  // One guard bit so rounding the max positive value cannot wrap.
  assign ext = {din[NB_IN-1], din};
  assign rnd = mode[MODE_RND_BIT] ? ext + signed'(half) : ext;
  assign sh  = NB_SH'(rnd >>> D);

  // Dropped MSBs and output sign must all agree.
  assign top = sh[NB_SH-1:NB_OUT-1];
  assign ovf = !((&top) || !(|top));

  assign sat = sh[NB_SH-1] ? {1'b1, {(NB_OUT-1){1'b0}}}
                           : {1'b0, {(NB_OUT-1){1'b1}}};

  assign dout = (ovf && mode[MODE_SAT_BIT]) ? sat
                                            : sh[NB_OUT-1:0];

endmodule

// File: rtl/fxp_accum_quant.sv
// Windowed fixed-point accumulator with run-time re-quantisation.
// Ports: i_clock, i_rst_n (sync, active low); bus (slave) samples/results.
module fxp_accum_quant
  import fxp_accum_quant_pkg::*;
#(
  parameter int NB_IN   = 16,
  parameter int NBF_IN  = 14,
  parameter int N_ACC   = 4,
  parameter int NB_OUT  = 11,
  parameter int NBF_OUT = 10
) (
  input logic               i_clock,
  input logic               i_rst_n,
  fxp_accum_quant_if.slave  bus
);

  localparam int NB_ACC = NB_IN + $clog2(N_ACC);
  localparam int CW     = $clog2(N_ACC);

  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_base;
  logic [CW-1:0]            cnt_nxt;
  logic signed [NB_ACC-1:0] acc;
  logic signed [NB_ACC-1:0] acc_nxt;
  logic signed [NB_ACC-1:0] x;
  logic                     last;
  logic                     done_q;
  mode_t                    mode_q;

  logic [NB_OUT-1:0]        q_data;
  logic                     q_ovf;

  logic                     valid_r;
  logic [NB_ACC-1:0]        acc_fr_r;
  logic [NB_OUT-1:0]        data_r;
  logic                     ovf_r;

  assign x = NB_ACC'(signed'(bus.i_data));

  // A clear restarts counting; a sample in the same cycle opens
  // the new window.
  always_comb begin
    cnt_base = bus.i_clear ? '0 : cnt;
    last     = bus.i_valid && (cnt_base == CW'(N_ACC - 1));
    cnt_nxt  = cnt_base;
    acc_nxt  = acc;
    if (bus.i_valid) begin
      acc_nxt = (cnt_base == '0) ? x : acc + x;
      cnt_nxt = last ? '0 : cnt_base + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      done_q <= 1'b0;
      mode_q <= MODE_TRUNC_WRAP;
    end else begin
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      done_q <= last;
      if (last) mode_q <= bus.i_mode;
    end
  end

  fxp_quantizer #(
    .NB_IN   (NB_ACC),
    .NBF_IN  (NBF_IN),
    .NB_OUT  (NB_OUT),
    .NBF_OUT (NBF_OUT)
  ) u_quant (
    .din  (acc),
    .mode (mode_q),
    .dout (q_data),
    .ovf  (q_ovf)
  );

  always_ff @(posedge i_clock) begin
    if (!i_rst_n) begin
      valid_r  <= 1'b0;
      acc_fr_r <= '0;
      data_r   <= '0;
      ovf_r    <= 1'b0;
    end else begin
      valid_r <= done_q;
      if (done_q) begin
        acc_fr_r <= acc;
        data_r   <= q_data;
        ovf_r    <= q_ovf;
      end
    end
  end

  assign bus.o_valid  = valid_r;
  assign bus.o_acc_fr = acc_fr_r;
  assign bus.o_data   = data_r;
  assign bus.o_ovf    = ovf_r;

endmodule

// File: tb/tb_fxp_accum_quant.sv
// Self-checking bench for fxp_accum_quant: directed cases plus
// randomized traffic against an integer-arithmetic reference model.
module tb_fxp_accum_quant;

  localparam int NB_IN   = 16;
  localparam int NBF_IN  = 14;
  localparam int N_ACC   = 4;
  localparam int NB_OUT  = 11;
  localparam int NBF_OUT = 10;
  localparam int NB_ACC  = NB_IN + $clog2(N_ACC);
  localparam int D       = NBF_IN - NBF_OUT;

  localparam longint OMAX  = (longint'(1) <<< (NB_OUT - 1)) - 1;
  localparam longint OMIN  = -(longint'(1) <<< (NB_OUT - 1));
  localparam longint OMASK = (longint'(1) <<< NB_OUT) - 1;
  localparam longint AMASK = (longint'(1) <<< NB_ACC) - 1;
  localparam longint HALF  = (D > 0) ? (longint'(1) <<< (D - 1)) : 0;

  typedef struct {
    int     due;
    longint acc;
    longint data;
    bit     ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  fxp_accum_quant_if #(
    .NB_IN  (NB_IN),
    .NB_OUT (NB_OUT),
    .NB_ACC (NB_ACC)
  ) bus ();

  fxp_accum_quant #(
    .NB_IN   (NB_IN),
    .NBF_IN  (NBF_IN),
    .N_ACC   (N_ACC),
    .NB_OUT  (NB_OUT),
    .NBF_OUT (NBF_OUT)
  ) dut (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  int     pulses = 0;
  exp_t   eq[$];
  longint win[$];
  longint last_acc  = 0;
  longint last_data = 0;
  bit     last_ovf  = 0;

  task automatic chk(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // Reference quantiser in plain integer arithmetic.
  function automatic void ref_q(input longint s,
                                input logic [1:0] m,
                                output longint d,
                                output bit ov);
    longint q;
    q  = m[0] ? ((s + HALF) >>> D) : (s >>> D);
    ov = (q > OMAX) || (q < OMIN);
    if (ov && m[1]) q = (q > OMAX) ? OMAX : OMIN;
    d = q & OMASK;
  endfunction

  task automatic step(bit v, logic [15:0] d, logic [1:0] m,
                      bit clr, bit rn);
    exp_t   e;
    longint s;
    bit     ev;
    bus.i_valid = v;
    bus.i_data  = d;
    bus.i_mode  = m;
    bus.i_clear = clr;
    rst_n       = rn;
    if (!rn) begin
      eq.delete();
      win.delete();
      last_acc  = 0;
      last_data = 0;
      last_ovf  = 0;
    end else begin
      if (clr) win.delete();
      if (v) win.push_back(longint'($signed(d)));
      if (win.size() == N_ACC) begin
        s = 0;
        foreach (win[i]) s += win[i];
        e.due = cyc + 2;
        e.acc = s & AMASK;
        ref_q(s, m, e.data, e.ovf);
        eq.push_back(e);
        win.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    ev = (eq.size() > 0) && (eq[0].due == cyc);
    if (ev) begin
      e = eq.pop_front();
      last_acc  = e.acc;
      last_data = e.data;
      last_ovf  = e.ovf;
      pulses++;
    end
    chk("o_valid", longint'(bus.o_valid), longint'(ev));
    chk("o_acc_fr", longint'(bus.o_acc_fr), last_acc);
    chk("o_data", longint'(bus.o_data), last_data);
    chk("o_ovf", longint'(bus.o_ovf), longint'(last_ovf));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, '0, 2'b00, 0, 1);
  endtask

  // Four equal samples, then the idle cycle where the result appears.
  task automatic win4(logic [15:0] d, logic [1:0] m);
    for (int i = 0; i < N_ACC; i++) step(1, d, m, 0, 1);
    step(0, '0, 2'b00, 0, 1);
  endtask

  initial begin
    int p0;
    bus.i_valid = 0;
    bus.i_data  = '0;
    bus.i_mode  = 2'b00;
    bus.i_clear = 0;
    rst_n       = 0;

    step(0, '0, 2'b00, 0, 0);
    step(1, 16'h7fff, 2'b11, 1, 0);
    idle(2);

    // +0.25 x4 = +1.0: out of S(11,10) range
    win4(16'h1000, 2'b00);
    chk("t1w_valid", longint'(bus.o_valid), 1);
    chk("t1w_data", longint'(bus.o_data), 'h400);
    chk("t1w_ovf", longint'(bus.o_ovf), 1);
    chk("t1w_acc", longint'(bus.o_acc_fr), 'h04000);
    win4(16'h1000, 2'b10);
    chk("t1s_data", longint'(bus.o_data), 'h3ff);
    chk("t1s_ovf", longint'(bus.o_ovf), 1);

    // sum 2^-11: half an output LSB
    win4(16'h0002, 2'b00);
    chk("t2t_data", longint'(bus.o_data), 'h000);
    chk("t2t_ovf", longint'(bus.o_ovf), 0);
    win4(16'h0002, 2'b01);
    chk("t2r_data", longint'(bus.o_data), 'h001);
    chk("t2r_ovf", longint'(bus.o_ovf), 0);

    // -1.0 x4 = -4.0
    win4(16'hc000, 2'b10);
    chk("t3s_data", longint'(bus.o_data), 'h400);
    chk("t3s_ovf", longint'(bus.o_ovf), 1);
    win4(16'hc000, 2'b00);
    chk("t3w_data", longint'(bus.o_data), 'h000);
    chk("t3w_ovf", longint'(bus.o_ovf), 1);

    // 8 back-to-back, then 8 with random gaps
    p0 = pulses;
    for (int i = 0; i < 8; i++)
      step(1, 16'($urandom), 2'($urandom), 0, 1);
    for (int i = 0; i < 8; i++) begin
      idle(int'($urandom_range(0, 3)));
      step(1, 16'($urandom), 2'($urandom), 0, 1);
    end
    idle(3);
    chk("t4_pulses", longint'(pulses - p0), 4);

    // reset mid-window discards the partial sum
    step(1, 16'h1000, 2'b00, 0, 1);
    step(1, 16'h1000, 2'b00, 0, 1);
    step(0, '0, 2'b00, 0, 0);
    chk("t5_rst_acc", longint'(bus.o_acc_fr), 0);
    win4(16'h0040, 2'b00);
    chk("t5_valid", longint'(bus.o_valid), 1);
    chk("t5_acc", longint'(bus.o_acc_fr), 'h100);

    // clear with a sample starts a fresh window
    for (int i = 0; i < 3; i++) step(1, 16'h0100, 2'b00, 0, 1);
    step(1, 16'h0200, 2'b00, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 16'h0010, 2'b00, 0, 1);
    step(0, '0, 2'b00, 0, 1);
    chk("t6_valid", longint'(bus.o_valid), 1);
    chk("t6_acc", longint'(bus.o_acc_fr), 'h230);

    // clear right after a window end still emits that result
    for (int i = 0; i < 4; i++) step(1, 16'h0008, 2'b01, 0, 1);
    step(0, '0, 2'b00, 1, 1);
    chk("t6b_valid", longint'(bus.o_valid), 1);

    // random traffic with occasional clear/reset
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0),
           16'($urandom),
           2'($urandom),
           bit'($urandom_range(0, 29) == 0),
           bit'($urandom_range(0, 79) != 0));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
